// File: rtl/alu_op_issue_pkg.sv
// Shared RV32I/ALU encodings for the ALU issue stage: control codes, opcodes,
// branch-condition tags and the decoder result record.
package riscv_alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SGE = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] ALU_ILL = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // How the execute stage must read the ALU zero flag for a branch.
    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQZ  = 2'b01,
        BR_NEZ  = 2'b10
    } br_cond_e;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] ctrl;
        logic                  b_sel_imm;
        br_cond_e              br;
        logic                  illegal;
    } dec_t;

    localparam dec_t DEC_ILLEGAL = '{ctrl: ALU_ILL, b_sel_imm: 1'b0, br: BR_NONE, illegal: 1'b1};

    function automatic dec_t mk_dec(input logic [ALU_CTRL_W-1:0] ctrl,
                                    input logic b_sel_imm, input br_cond_e br);
        dec_t d;
        d.ctrl      = ctrl;
        d.b_sel_imm = b_sel_imm;
        d.br        = br;
        d.illegal   = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// Upstream (register-read) and downstream (execute) handshake bundle of the
// ALU issue stage; slave is the issue stage itself.
interface alu_op_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_BITS  = 4,
    parameter int CNT_BITS   = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;
    logic [DATA_WIDTH-1:0] imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_BITS-1:0]  alu_ctrl;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [1:0]            br_cond;
    logic                  illegal;
    logic [CNT_BITS-1:0]   illegal_cnt;

    modport slave (
        input  in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_a, alu_b, br_cond, illegal, illegal_cnt
    );

    modport master (
        output in_valid, opcode, funct3, funct7, rs1_val, rs2_val, imm, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_a, alu_b, br_cond, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_op_issue_dec.sv
// Combinational RV32I opcode/funct decoder producing ALU control, operand-b
// select, branch zero-flag interpretation and the illegal flag.
module alu_op_dec
    import riscv_alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       o_dec
);

    // Decode table; anything not listed falls back to the illegal record.
    always_comb begin
        o_dec = DEC_ILLEGAL;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  o_dec = mk_dec(ALU_ADD, 1'b0, BR_NONE);
                        3'b111:  o_dec = mk_dec(ALU_AND, 1'b0, BR_NONE);
                        3'b110:  o_dec = mk_dec(ALU_OR,  1'b0, BR_NONE);
                        3'b010:  o_dec = mk_dec(ALU_SLT, 1'b0, BR_NONE);
                        default: o_dec = DEC_ILLEGAL;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    o_dec = mk_dec(ALU_SUB, 1'b0, BR_NONE);
                end else begin
                    o_dec = DEC_ILLEGAL;
                end
            end
            OP_I: begin
                case (funct3)
                    3'b000:  o_dec = mk_dec(ALU_ADD, 1'b1, BR_NONE);
                    3'b111:  o_dec = mk_dec(ALU_AND, 1'b1, BR_NONE);
                    3'b110:  o_dec = mk_dec(ALU_OR,  1'b1, BR_NONE);
                    3'b010:  o_dec = mk_dec(ALU_SLT, 1'b1, BR_NONE);
                    default: o_dec = DEC_ILLEGAL;
                endcase
            end
            OP_LOAD, OP_STORE: o_dec = mk_dec(ALU_ADD, 1'b1, BR_NONE);
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  o_dec = mk_dec(ALU_SUB, 1'b0, BR_EQZ);
                    3'b001:  o_dec = mk_dec(ALU_SUB, 1'b0, BR_NEZ);
                    3'b100:  o_dec = mk_dec(ALU_SLT, 1'b0, BR_NEZ);
                    3'b101:  o_dec = mk_dec(ALU_SGE, 1'b0, BR_NEZ);
                    default: o_dec = DEC_ILLEGAL;
                endcase
            end
            default: o_dec = DEC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_op_issue.sv
// Registered ALU issue stage: decodes the incoming op and holds it in a
// two-entry (output + skid) buffer so the stage sustains one op per cycle.
module alu_op_issue
    import riscv_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_BITS  = 4,
    parameter int CNT_BITS   = 8
) (
    input  logic           clk,
    input  logic           rst,
    alu_op_issue_if.slave  bus
);

    typedef struct packed {
        logic [CTRL_BITS-1:0]  ctrl;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [1:0]            br;
        logic                  illegal;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_e;

    state_e              r_state;
    entry_t              r_out;
    entry_t              r_skid;
    logic [CNT_BITS-1:0] r_cnt;

    dec_t   w_dec;
    entry_t w_entry;
    logic   w_in_ready;
    logic   w_out_valid;
    logic   w_acc;
    logic   w_drn;

    alu_op_dec u_dec (
        .opcode (bus.opcode),
        .funct3 (bus.funct3),
        .funct7 (bus.funct7),
        .o_dec  (w_dec)
    );

    assign w_in_ready  = (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_acc       = bus.in_valid && w_in_ready;
    assign w_drn       = w_out_valid && bus.out_ready;

    // Assemble the entry that an accepted op will occupy.
    always_comb begin
        w_entry.ctrl    = CTRL_BITS'(w_dec.ctrl);
        w_entry.a       = bus.rs1_val;
        w_entry.br      = w_dec.br;
        w_entry.illegal = w_dec.illegal;
        if (w_dec.b_sel_imm) begin
            w_entry.b = bus.imm;
        end else begin
            w_entry.b = bus.rs2_val;
        end
    end

    // Skid FSM: the output register always holds the oldest op, skid the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_out   <= w_entry;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_drn) begin
                        r_out <= w_entry;
                    end else if (w_acc) begin
                        r_skid  <= w_entry;
                        r_state <= S_FULL;
                    end else if (w_drn) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drn) begin
                        r_out   <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Saturating count of accepted illegal ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_acc && w_dec.illegal && (r_cnt != {CNT_BITS{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.alu_ctrl    = r_out.ctrl;
    assign bus.alu_a       = r_out.a;
    assign bus.alu_b       = r_out.b;
    assign bus.br_cond     = r_out.br;
    assign bus.illegal     = r_out.illegal;
    assign bus.illegal_cnt = r_cnt;

endmodule
